// File: rtl/mem_line_arbiter_if.sv
// Line-memory port bundle: read/write request, line address, write line,
// read line and a one-cycle completion pulse. The master issues requests,
// the slave answers with rdata/ready.
interface mem_line_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] rdata;
  logic              ready;

  modport master (output read, write, addr, wdata, input  rdata, ready);
  modport slave  (input  read, write, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: shares one line-memory port between I-cache and D-cache.
// The winner's request is registered onto the shared port and held until the
// memory's ready pulse, which is steered back to the winner combinationally.
// Optional feature macro ARB_RR_EN: round-robin tie-break (default build uses
// fixed priority with D winning ties).
module mem_line_arbiter #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_line_arbiter_if.slave  i_port,
  mem_line_arbiter_if.slave  d_port,
  mem_line_arbiter_if.master mem_port,
  output logic               grant_i,
  output logic               grant_d
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  logic [0:0] state_q, state_d;
  req_t       cur_q, cur_d;
  logic       gnt_i_q, gnt_i_d;
  logic       gnt_d_q, gnt_d_d;
  logic       last_d_q, last_d_d;   // last grant: 0 = I, 1 = D

  req_t req_i, req_d, req_sel;
  logic i_req, d_req, tie_d, pick_d;

  assign req_i = '{rd: i_port.read, wr: i_port.write, addr: i_port.addr, wdata: i_port.wdata};
  assign req_d = '{rd: d_port.read, wr: d_port.write, addr: d_port.addr, wdata: d_port.wdata};
  assign i_req = i_port.read | i_port.write;
  assign d_req = d_port.read | d_port.write;

`ifdef ARB_RR_EN
  // On a tie the side that did not win last time goes next.
  assign tie_d = ~last_d_q;
`else
  // Fixed priority: D always wins ties.
  assign tie_d = 1'b1;
`endif

  assign pick_d  = d_req & (~i_req | tie_d);
  assign req_sel = pick_d ? req_d : req_i;

  // Next-state: grant and latch in IDLE, hold until mem ready in BUSY.
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    gnt_i_d  = gnt_i_q;
    gnt_d_d  = gnt_d_q;
    last_d_d = last_d_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          state_d  = ST_BUSY;
          cur_d    = req_sel;
          // read+write together is a protocol error: forward the write only
          cur_d.rd = req_sel.rd & ~req_sel.wr;
          gnt_i_d  = ~pick_d;
          gnt_d_d  = pick_d;
          last_d_d = pick_d;
        end
      end
      ST_BUSY: begin
        if (mem_port.ready) begin
          state_d  = ST_IDLE;
          cur_d.rd = 1'b0;
          cur_d.wr = 1'b0;
          gnt_i_d  = 1'b0;
          gnt_d_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cur_d.rd = 1'b0;
        cur_d.wr = 1'b0;
        gnt_i_d  = 1'b0;
        gnt_d_d  = 1'b0;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      gnt_i_q  <= 1'b0;
      gnt_d_q  <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      gnt_i_q  <= gnt_i_d;
      gnt_d_q  <= gnt_d_d;
      last_d_q <= last_d_d;
    end
  end

  assign mem_port.read  = cur_q.rd;
  assign mem_port.write = cur_q.wr;
  assign mem_port.addr  = cur_q.addr;
  assign mem_port.wdata = cur_q.wdata;
  assign grant_i        = gnt_i_q;
  assign grant_d        = gnt_d_q;

  // Grants are only set while BUSY, so a ready seen in IDLE goes nowhere.
  assign i_port.ready = (state_q == ST_BUSY) & gnt_i_q & mem_port.ready;
  assign d_port.ready = (state_q == ST_BUSY) & gnt_d_q & mem_port.ready;
  assign i_port.rdata = mem_port.rdata;
  assign d_port.rdata = mem_port.rdata;

endmodule
